mips_ctrl_pipe: RTL and testbench

MIPS_CTRL_PIPE -- requirements
Module: mips_ctrl_pipe

---
 rtl/mips_ctrl_pipe_if.sv | 37 +++
 rtl/mips_ctrl_pipe.sv | 192 +++++++++++++++++++
 tb/tb_mips_ctrl_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pipe_if.sv
// Decode/execute control bundle for mips_ctrl_pipe: decode-side inputs, EX-stage control outputs,
// and a debug view of the controller state.
interface mips_ctrl_pipe_if #(
  parameter int SHAMT_W = 5
) ();
  // Handshake: instr_valid is the offer and stall_FETCH is the inverse of ready. An instruction is
  // accepted on a rising edge where instr_valid=1 and stall_FETCH=0. While stall_FETCH=1 the upstream
  // stage holds instruction_ID stable and the EX slot receives a bubble.
  logic              instr_valid;
  logic [31:0]       instruction_ID;
  logic              zero_EX;
  logic [3:0]        alu_op;
  logic [SHAMT_W-1:0] shamt_EX;
  logic [1:0]        regsel_EX;
  logic              enhilo_EX;
  logic              regwrite_EX;
  logic              rdrt_EX;
  logic [1:0]        alu_src_EX;
  logic              pc_src_EX;
  logic              stall_FETCH;
  logic              gpio_out_en;
  logic              gpio_in_en;
  logic              illegal_EX;
  logic [1:0]        dbg_state;

  modport master (
    output instr_valid, instruction_ID, zero_EX,
    input  alu_op, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX, rdrt_EX, alu_src_EX,
    input  pc_src_EX, stall_FETCH, gpio_out_en, gpio_in_en, illegal_EX, dbg_state
  );

  modport slave (
    input  instr_valid, instruction_ID, zero_EX,
    output alu_op, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX, rdrt_EX, alu_src_EX,
    output pc_src_EX, stall_FETCH, gpio_out_en, gpio_in_en, illegal_EX, dbg_state
  );
endinterface

// File: rtl/mips_ctrl_pipe.sv
// MIPS decode-to-EX control stage with branch squash and HI/LO multiply interlock.
// Optional GPIO strobes on shamt=0 srl/sra are enabled by defining MIPS_CTRL_GPIO_EN.
module mips_ctrl_pipe #(
  parameter int SHAMT_W     = 5,
  parameter int MULT_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  mips_ctrl_pipe_if.slave bus
);
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_SQUASH = 2'd1,
    MUL_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]         alu_op;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         regsel;
    logic               enhilo;
    logic               regwrite;
    logic               rdrt;
    logic [1:0]         alu_src;
    logic               illegal;
    logic               is_bne;
  } ex_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);

  state_t             state, state_next;
  ex_t                dec, ex_q;
  logic               hilo_dep;
  logic [3:0]         busy_cnt, busy_next;
  logic               taken, hazard, stall, issue;
  logic [5:0]         opcode, funct;
  logic [SHAMT_W-1:0] shamt_f;

  assign opcode  = bus.instruction_ID[31:26];
  assign funct   = bus.instruction_ID[5:0];
  assign shamt_f = bus.instruction_ID[6+SHAMT_W-1:6];

`ifdef MIPS_CTRL_GPIO_EN
  logic dec_gpio_out, dec_gpio_in, gpio_out_q, gpio_in_q;
`endif

  always_comb begin
    dec      = '0;
    hilo_dep = 1'b0;
`ifdef MIPS_CTRL_GPIO_EN
    dec_gpio_out = 1'b0;
    dec_gpio_in  = 1'b0;
`endif
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: begin dec.alu_op = 4'b0100; dec.regwrite = 1'b1; end
          6'b100010, 6'b100011: begin dec.alu_op = 4'b0101; dec.regwrite = 1'b1; end
          6'b100100: begin dec.alu_op = 4'b0000; dec.regwrite = 1'b1; end
          6'b100101: begin dec.alu_op = 4'b0001; dec.regwrite = 1'b1; end
          6'b100111: begin dec.alu_op = 4'b0010; dec.regwrite = 1'b1; end
          6'b100110: begin dec.alu_op = 4'b0011; dec.regwrite = 1'b1; end
          6'b101010: begin dec.alu_op = 4'b1100; dec.regwrite = 1'b1; end
          6'b101011: begin dec.alu_op = 4'b1101; dec.regwrite = 1'b1; end
          6'b011000: begin dec.alu_op = 4'b0110; dec.enhilo = 1'b1; hilo_dep = 1'b1; end
          6'b011001: begin dec.alu_op = 4'b0111; dec.enhilo = 1'b1; hilo_dep = 1'b1; end
          6'b010000: begin dec.regsel = 2'd1; dec.regwrite = 1'b1; hilo_dep = 1'b1; end
          6'b010010: begin dec.regsel = 2'd2; dec.regwrite = 1'b1; hilo_dep = 1'b1; end
          // The all-zero word is the canonical NOP and stays a bubble.
          6'b000000: begin
            if (bus.instruction_ID != 32'd0) begin
              dec.alu_op   = 4'b1000;
              dec.shamt    = shamt_f;
              dec.regwrite = 1'b1;
            end
          end
          6'b000010: begin
`ifdef MIPS_CTRL_GPIO_EN
            if (shamt_f == '0) begin
              dec_gpio_out = 1'b1;
            end else begin
              dec.alu_op   = 4'b1001;
              dec.shamt    = shamt_f;
              dec.regwrite = 1'b1;
            end
`else
            dec.alu_op   = 4'b1001;
            dec.shamt    = shamt_f;
            dec.regwrite = 1'b1;
`endif
          end
          6'b000011: begin
`ifdef MIPS_CTRL_GPIO_EN
            if (shamt_f == '0) begin
              dec_gpio_in  = 1'b1;
              dec.regwrite = 1'b1;
            end else begin
              dec.alu_op   = 4'b1010;
              dec.shamt    = shamt_f;
              dec.regwrite = 1'b1;
            end
`else
            dec.alu_op   = 4'b1010;
            dec.shamt    = shamt_f;
            dec.regwrite = 1'b1;
`endif
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin
        dec.alu_op = 4'b0100; dec.alu_src = 2'd1; dec.rdrt = 1'b1; dec.regwrite = 1'b1;
      end
      6'b001101: begin
        dec.alu_op = 4'b0001; dec.alu_src = 2'd2; dec.rdrt = 1'b1; dec.regwrite = 1'b1;
      end
      6'b001111: begin
        dec.alu_op   = 4'b1000;
        dec.shamt    = SHAMT_W'(16);
        dec.alu_src  = 2'd2;
        dec.rdrt     = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b000101: begin dec.alu_op = 4'b0101; dec.is_bne = 1'b1; end
      default:   dec.illegal = 1'b1;
    endcase
  end

  // A squash slot discards the decoded instruction rather than holding it, so the
  // interlock only stalls outside BR_SQUASH; a taken branch wins over the interlock.
  always_comb begin
    state_next = state;
    busy_next  = busy_cnt;
    taken      = ex_q.is_bne && !bus.zero_EX && (state != BR_SQUASH);
    hazard     = bus.instr_valid && hilo_dep && (busy_cnt != 4'd0) && (state != BR_SQUASH);
    stall      = taken || hazard;
    issue      = bus.instr_valid && !stall && (state != BR_SQUASH);
    if (issue && dec.enhilo) begin
      busy_next = MULT_LOAD;
    end else if (busy_cnt != 4'd0) begin
      busy_next = busy_cnt - 4'd1;
    end
    if (taken) begin
      state_next = BR_SQUASH;
    end else if (busy_next != 4'd0) begin
      state_next = MUL_WAIT;
    end else begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      busy_cnt <= 4'd0;
      ex_q     <= '0;
    end else begin
      state    <= state_next;
      busy_cnt <= busy_next;
      ex_q     <= issue ? dec : '0;
    end
  end

`ifdef MIPS_CTRL_GPIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= 1'b0;
      gpio_in_q  <= 1'b0;
    end else begin
      gpio_out_q <= issue && dec_gpio_out;
      gpio_in_q  <= issue && dec_gpio_in;
    end
  end
  assign bus.gpio_out_en = gpio_out_q;
  assign bus.gpio_in_en  = gpio_in_q;
`else
  assign bus.gpio_out_en = 1'b0;
  assign bus.gpio_in_en  = 1'b0;
`endif

  assign bus.alu_op      = ex_q.alu_op;
  assign bus.shamt_EX    = ex_q.shamt;
  assign bus.regsel_EX   = ex_q.regsel;
  assign bus.enhilo_EX   = ex_q.enhilo;
  assign bus.regwrite_EX = ex_q.regwrite;
  assign bus.rdrt_EX     = ex_q.rdrt;
  assign bus.alu_src_EX  = ex_q.alu_src;
  assign bus.illegal_EX  = ex_q.illegal;
  assign bus.pc_src_EX   = taken;
  assign bus.stall_FETCH = stall;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed bench for mips_ctrl_pipe: decode table, multiply interlock, branch squash and reset.
module tb_mips_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   stall_cycles;
  int   enh_cnt;

  mips_ctrl_pipe_if #(.SHAMT_W(5)) bus ();

  mips_ctrl_pipe #(.SHAMT_W(5), .MULT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SLL  = 32'h00031100;
  localparam logic [31:0] I_SRA  = 32'h000310C3;
  localparam logic [31:0] I_SLT  = 32'h0022182A;
  localparam logic [31:0] I_ORI  = 32'h340500FF;
  localparam logic [31:0] I_LUI  = 32'h3C061234;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_SRL0 = 32'h00040002;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_MFLO = 32'h00002012;
  localparam logic [31:0] I_MFHI = 32'h00002810;
  localparam logic [31:0] I_BNE  = 32'h14220004;
  localparam logic [31:0] I_ADDI = 32'h20230005;

  logic [31:0] e_add, e_sll, e_sra, e_slt, e_ori, e_lui, e_ill, e_srl0;
  logic [31:0] e_mult, e_mflo, e_mfhi, e_bne, e_addi;

  function automatic logic [31:0] exv(input logic [3:0] alu, input logic [4:0] sh,
                                      input logic [1:0] rs, input logic en, input logic rw,
                                      input logic rdrt, input logic [1:0] src, input logic ill,
                                      input logic go, input logic gi);
    return {13'd0, alu, sh, rs, en, rw, rdrt, src, ill, go, gi};
  endfunction

  function automatic logic [31:0] obs_ex();
    return {13'd0, bus.alu_op, bus.shamt_EX, bus.regsel_EX, bus.enhilo_EX, bus.regwrite_EX,
            bus.rdrt_EX, bus.alu_src_EX, bus.illegal_EX, bus.gpio_out_en, bus.gpio_in_en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic z);
    bus.instr_valid    = v;
    bus.instruction_ID = ins;
    bus.zero_EX        = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode_one(input string tag, input logic [31:0] ins, input logic [31:0] exp);
    drive(1'b1, ins, 1'b1);
    tick();
    chk(tag, obs_ex(), exp);
  endtask

  initial begin
    e_add  = exv(4'b0100, 5'd0,  2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_sll  = exv(4'b1000, 5'd4,  2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_sra  = exv(4'b1010, 5'd3,  2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_slt  = exv(4'b1100, 5'd0,  2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_ori  = exv(4'b0001, 5'd0,  2'd0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    e_lui  = exv(4'b1000, 5'd16, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    e_ill  = exv(4'b0000, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
`ifdef MIPS_CTRL_GPIO_EN
    e_srl0 = exv(4'b0000, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
`else
    e_srl0 = exv(4'b1001, 5'd0,  2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`endif
    e_mult = exv(4'b0110, 5'd0,  2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_mflo = exv(4'b0000, 5'd0,  2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_mfhi = exv(4'b0000, 5'd0,  2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_bne  = exv(4'b0101, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    e_addi = exv(4'b0100, 5'd0,  2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

    // Reset state
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ex", obs_ex(), 32'd0);
    chk("reset_pc_stall", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd0);
    chk("reset_state", 32'(bus.dbg_state), 32'd0);

    // Decode table, one cycle latency
    decode_one("add", I_ADD, e_add);
    decode_one("sll", I_SLL, e_sll);
    decode_one("sra", I_SRA, e_sra);
    decode_one("slt", I_SLT, e_slt);
    decode_one("ori", I_ORI, e_ori);
    decode_one("lui", I_LUI, e_lui);
    decode_one("nop", 32'd0, 32'd0);
    decode_one("illegal", I_ILL, e_ill);
    drive(1'b0, 32'd0, 1'b1);
    tick();
    chk("illegal_one_cycle", obs_ex(), 32'd0);
    decode_one("srl_shamt0", I_SRL0, e_srl0);
    decode_one("invalid_bubble", 32'd0, 32'd0);
    drive(1'b0, I_ADD, 1'b1);
    tick();
    chk("valid_low_bubble", obs_ex(), 32'd0);

    // mult followed by mflo: four interlock cycles
    drive(1'b1, I_MULT, 1'b1);
    tick();
    chk("mult_issue", obs_ex(), e_mult);
    enh_cnt = 32'(bus.enhilo_EX);
    drive(1'b1, I_MFLO, 1'b1);
    stall_cycles = 0;
    for (int i = 0; i < 10 && bus.stall_FETCH; i++) begin
      stall_cycles++;
      tick();
      enh_cnt += 32'(bus.enhilo_EX);
    end
    chk("mflo_stall_len", stall_cycles, 32'd4);
    chk("enhilo_pulses", enh_cnt, 32'd1);
    tick();
    chk("mflo_issue", obs_ex(), e_mflo);

    // Unrelated instruction during busy issues without stall
    drive(1'b1, I_MULT, 1'b1);
    tick();
    chk("busy_state", 32'(bus.dbg_state), 32'd2);
    drive(1'b1, I_ADD, 1'b1);
    chk("add_no_stall", 32'(bus.stall_FETCH), 32'd0);
    tick();
    chk("add_during_busy", obs_ex(), e_add);
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("busy_drained", 32'(bus.dbg_state), 32'd0);

    // Taken bne: redirect, then squash
    drive(1'b1, I_BNE, 1'b1);
    tick();
    chk("bne_ex", obs_ex(), e_bne);
    drive(1'b1, I_ADDI, 1'b0);
    chk("bne_taken", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd3);
    tick();
    drive(1'b1, I_ADDI, 1'b1);
    chk("squash_state", 32'(bus.dbg_state), 32'd1);
    chk("squash_ex", obs_ex(), 32'd0);
    chk("squash_pc_stall", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd0);
    tick();
    chk("squash_slot_bubble", obs_ex(), 32'd0);
    chk("squash_back_run", 32'(bus.dbg_state), 32'd0);
    tick();
    chk("addi_after_branch", obs_ex(), e_addi);

    // Not-taken bne
    drive(1'b1, I_BNE, 1'b1);
    tick();
    drive(1'b1, I_ADDI, 1'b1);
    chk("bne_not_taken", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd0);
    tick();
    chk("addi_no_squash", obs_ex(), e_addi);

    // Reset in second MUL_WAIT cycle
    drive(1'b1, I_MULT, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    tick();
    chk("mul_wait_2nd", 32'(bus.dbg_state), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ex", obs_ex(), 32'd0);
    chk("rst_mid_pc_stall", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd0);
    chk("rst_mid_state", 32'(bus.dbg_state), 32'd0);
    drive(1'b1, I_MFHI, 1'b1);
    chk("mfhi_no_stall", 32'(bus.stall_FETCH), 32'd0);
    tick();
    chk("mfhi_issue", obs_ex(), e_mfhi);

    // Taken bne in final busy cycle; squashed mult must not reload
    drive(1'b1, I_MULT, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    tick();
    tick();
    drive(1'b1, I_BNE, 1'b1);
    tick();
    drive(1'b1, I_MULT, 1'b0);
    chk("final_busy_taken", 32'({bus.pc_src_EX, bus.stall_FETCH}), 32'd3);
    tick();
    drive(1'b1, I_MULT, 1'b1);
    chk("final_squash_state", 32'(bus.dbg_state), 32'd1);
    chk("final_squash_ex", obs_ex(), 32'd0);
    tick();
    chk("final_run_state", 32'(bus.dbg_state), 32'd0);
    chk("final_no_reload_ex", obs_ex(), 32'd0);
    drive(1'b1, I_MFLO, 1'b1);
    chk("final_mflo_no_stall", 32'(bus.stall_FETCH), 32'd0);
    tick();
    chk("final_mflo_issue", obs_ex(), e_mflo);
    drive(1'b0, 32'd0, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
